// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: 2x-upscaled VGA scanout reads take absolute priority,
// and game-logic writes fill every other cycle. Sync/valid are delayed to match rgb.
module vga_fb_arbiter #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               valid,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               valid_o,
  output logic               vblank_pulse
);

  localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);

  // Constant-coefficient multiply expanded into shifted adds (320 -> 256 + 64).
  function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (FB_W[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  logic              scan_slot;
  logic              wr_slot;
  logic              in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        tag;
  logic [2:0]        vld_d;
  logic [2:0]        hs_d;
  logic [2:0]        vs_d;

  always_comb begin
    scan_slot = valid & ~h_cnt[0];
    wr_slot   = ~scan_slot & wr_req & ~wr_ack;
    in_range  = 32'(wr_addr) < FB_SIZE;
    rd_addr   = row_base(v_cnt[9:1]) + ADDR_W'(h_cnt[9:1]);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      mem_en <= scan_slot | (wr_slot & in_range);
      mem_we <= wr_slot & in_range;
      wr_ack <= wr_slot;
      if (scan_slot) begin
        mem_addr <= rd_addr;
      end else if (wr_slot && in_range) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  // tag[1] lines up with mem_rdata of a scanout read; odd columns hold the pixel.
  always_ff @(posedge pclk) begin
    if (reset) begin
      tag          <= '0;
      vld_d        <= '0;
      hs_d         <= '1;
      vs_d         <= '1;
      rgb          <= '0;
      vblank_pulse <= 1'b0;
    end else begin
      tag          <= {tag[0], scan_slot};
      vld_d        <= {vld_d[1:0], valid};
      hs_d         <= {hs_d[1:0], hsync_i};
      vs_d         <= {vs_d[1:0], vsync_i};
      vblank_pulse <= vs_d[2] & ~vs_d[1];
      if (!vld_d[1])  rgb <= '0;
      else if (tag[1]) rgb <= mem_rdata;
    end
  end

  assign valid_o = vld_d[2];
  assign hsync_o = hs_d[2];
  assign vsync_o = vs_d[2];

endmodule
